gamma_sel_ctrl: RTL and testbench



---
 rtl/gamma_pkg.sv | 27 ++
 rtl/key_debounce.sv | 44 ++++
 rtl/gamma_sel_ctrl.sv | 124 ++++++++++++
 tb/tb_gamma_sel_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/gamma_pkg.sv
// Shared gamma-select definitions: level range, controller states and the
// level-to-display-code mapping used by the LUT loader and the 7-seg decoder.
package gamma_pkg;

  localparam int GAMMA_LEVELS  = 10;
  localparam int GAMMA_RST_LVL = 4;

  typedef logic [3:0]              lvl_t;
  typedef logic [GAMMA_LEVELS-1:0] dig_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_FRM = 2'd1,
    ST_REQ      = 2'd2
  } gamma_state_t;

  // Code 0 is the neutral 1.0 setting so the display and LUT default to slot 0.
  function automatic lvl_t lvl2code(input lvl_t lvl);
    if (lvl == lvl_t'(GAMMA_RST_LVL))
      return lvl_t'(0);
    else if (lvl < lvl_t'(GAMMA_RST_LVL))
      return lvl + lvl_t'(1);
    else
      return lvl;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low pushbutton conditioner: 2-FF synchronizer, stability counter,
// and a single-cycle press pulse on the debounced release->press transition.
module key_debounce #(
  parameter int DEB_CYCLES = 50000,
  parameter int DEB_W      = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             deb;
  logic [DEB_W-1:0] cnt;

  // Any return of the synchronized level to the debounced one restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      deb   <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb   <= sync2;
        cnt   <= '0;
        press <= deb;
      end else begin
        cnt <= cnt + DEB_W'(1);
      end
    end
  end

endmodule

// File: rtl/gamma_sel_ctrl.sv
// Gamma selection controller: steps a pending level from two debounced keys and
// commits it to the LUT loader at frame boundaries through a req/ack handshake.
module gamma_sel_ctrl
  import gamma_pkg::*;
#(
  parameter int DEB_CYCLES = 50000,
  parameter int DEB_W      = 16
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iKEY_UP,
  input  logic        iKEY_DN,
  input  logic        iVS_PULSE,
  input  logic        iLOAD_ACK,
  output logic        oLOAD_REQ,
  output logic [3:0]  oLOAD_SEL,
  output logic [3:0]  oGAMMA_SEL,
  output logic [9:0]  oDIG,
  output logic        oBUSY
);

  logic up_ev;
  logic dn_ev;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_key_up (
    .clk   (iCLK),
    .rst_n (iRST_N),
    .key   (iKEY_UP),
    .press (up_ev)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_key_dn (
    .clk   (iCLK),
    .rst_n (iRST_N),
    .key   (iKEY_DN),
    .press (dn_ev)
  );

  gamma_state_t state_q, state_d;
  lvl_t         pending_q;
  lvl_t         applied_q, applied_d;
  lvl_t         load_lvl_q, load_lvl_d;
  lvl_t         load_sel_q, load_sel_d;
  lvl_t         gamma_sel_q, gamma_sel_d;
  logic         req_q, req_d;
  dig_t         dig_q;

  // Coincident up/down events cancel; both directions saturate.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      pending_q <= lvl_t'(GAMMA_RST_LVL);
      dig_q     <= dig_t'(1);
    end else begin
      if (up_ev && !dn_ev && pending_q != lvl_t'(GAMMA_LEVELS - 1))
        pending_q <= pending_q + lvl_t'(1);
      else if (dn_ev && !up_ev && pending_q != lvl_t'(0))
        pending_q <= pending_q - lvl_t'(1);
      dig_q <= dig_t'(1) << lvl2code(pending_q);
    end
  end

  always_comb begin
    state_d     = state_q;
    applied_d   = applied_q;
    load_lvl_d  = load_lvl_q;
    load_sel_d  = load_sel_q;
    gamma_sel_d = gamma_sel_q;
    req_d       = req_q;
    case (state_q)
      ST_IDLE: begin
        if (pending_q != applied_q)
          state_d = ST_WAIT_FRM;
      end
      ST_WAIT_FRM: begin
        // A cancelled change wins over a coincident frame strobe.
        if (pending_q == applied_q) begin
          state_d = ST_IDLE;
        end else if (iVS_PULSE) begin
          load_lvl_d = pending_q;
          load_sel_d = lvl2code(pending_q);
          req_d      = 1'b1;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (iLOAD_ACK) begin
          req_d       = 1'b0;
          applied_d   = load_lvl_q;
          gamma_sel_d = load_sel_q;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= ST_IDLE;
      applied_q   <= lvl_t'(GAMMA_RST_LVL);
      load_lvl_q  <= lvl_t'(GAMMA_RST_LVL);
      load_sel_q  <= lvl_t'(0);
      gamma_sel_q <= lvl_t'(0);
      req_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      applied_q   <= applied_d;
      load_lvl_q  <= load_lvl_d;
      load_sel_q  <= load_sel_d;
      gamma_sel_q <= gamma_sel_d;
      req_q       <= req_d;
    end
  end

  assign oLOAD_REQ  = req_q;
  assign oLOAD_SEL  = load_sel_q;
  assign oGAMMA_SEL = gamma_sel_q;
  assign oDIG       = dig_q;
  assign oBUSY      = (state_q != ST_IDLE) || (pending_q != applied_q);

endmodule

// File: tb/tb_gamma_sel_ctrl.sv
// Randomized bench for gamma_sel_ctrl against a level/handshake reference model.
module tb_gamma_sel_ctrl;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic       iKEY_UP = 1'b1;
  logic       iKEY_DN = 1'b1;
  logic       iVS_PULSE = 1'b0;
  logic       iLOAD_ACK = 1'b0;
  logic       oLOAD_REQ;
  logic [3:0] oLOAD_SEL;
  logic [3:0] oGAMMA_SEL;
  logic [9:0] oDIG;
  logic       oBUSY;

  gamma_sel_ctrl #(.DEB_CYCLES(4), .DEB_W(16)) dut (
    .iCLK       (iCLK),
    .iRST_N     (iRST_N),
    .iKEY_UP    (iKEY_UP),
    .iKEY_DN    (iKEY_DN),
    .iVS_PULSE  (iVS_PULSE),
    .iLOAD_ACK  (iLOAD_ACK),
    .oLOAD_REQ  (oLOAD_REQ),
    .oLOAD_SEL  (oLOAD_SEL),
    .oGAMMA_SEL (oGAMMA_SEL),
    .oDIG       (oDIG),
    .oBUSY      (oBUSY)
  );

  always #5 iCLK = ~iCLK;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: levels as plain integers, plus what the bench has latched.
  int  m_pend  = 4;
  int  m_appl  = 4;
  int  m_latch = 4;
  bit  in_req  = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int code_of(input int lvl);
    if (lvl == 4) return 0;
    return (lvl < 4) ? lvl + 1 : lvl;
  endfunction

  function automatic int onehot_of(input int lvl);
    return 1 << code_of(lvl);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic check_steady(input string tag);
    check_val({tag, "_dig"}, int'(oDIG), onehot_of(m_pend));
    check_val({tag, "_busy"}, int'(oBUSY), int'(in_req || (m_pend != m_appl)));
  endtask

  // One bouncy key press, held well past the debounce window, then released.
  task automatic press(input bit up, input bit dn);
    iKEY_UP = ~up; iKEY_DN = ~dn;
    tick(1);
    iKEY_UP = 1'b1; iKEY_DN = 1'b1;
    tick(1);
    iKEY_UP = ~up; iKEY_DN = ~dn;
    tick(10);
    iKEY_UP = 1'b1; iKEY_DN = 1'b1;
    tick(10);
    if (up && !dn) m_pend = (m_pend < 9) ? m_pend + 1 : 9;
    else if (dn && !up) m_pend = (m_pend > 0) ? m_pend - 1 : 0;
    check_steady("press");
  endtask

  task automatic glitch();
    int len = $urandom_range(1, 3);
    bit which = 1'($urandom_range(0, 1));
    if (which) iKEY_UP = 1'b0; else iKEY_DN = 1'b0;
    tick(len);
    iKEY_UP = 1'b1; iKEY_DN = 1'b1;
    tick(8);
    check_steady("glitch");
  endtask

  task automatic frame();
    tick(2);
    iVS_PULSE = 1'b1;
    tick(1);
    iVS_PULSE = 1'b0;
    if (m_pend != m_appl) begin
      m_latch = m_pend;
      in_req  = 1;
      check_val("frame_req", int'(oLOAD_REQ), 1);
      check_val("frame_sel", int'(oLOAD_SEL), code_of(m_latch));
    end else begin
      check_val("frame_noreq", int'(oLOAD_REQ), 0);
    end
    check_val("frame_busy", int'(oBUSY), int'(in_req || (m_pend != m_appl)));
  endtask

  task automatic ack(input int hold, input int mid_press);
    for (int i = 0; i < hold; i++) begin
      tick(1);
      check_val("hold_req", int'(oLOAD_REQ), 1);
      check_val("hold_sel", int'(oLOAD_SEL), code_of(m_latch));
    end
    if (mid_press == 1) press(1, 0);
    if (mid_press == 2) press(0, 1);
    if (mid_press != 0) begin
      check_val("mid_req", int'(oLOAD_REQ), 1);
      check_val("mid_sel", int'(oLOAD_SEL), code_of(m_latch));
    end
    iLOAD_ACK = 1'b1;
    tick(1);
    iLOAD_ACK = 1'b0;
    m_appl = m_latch;
    in_req = 0;
    check_val("ack_req", int'(oLOAD_REQ), 0);
    check_val("ack_gsel", int'(oGAMMA_SEL), code_of(m_appl));
    check_val("ack_busy", int'(oBUSY), int'(m_pend != m_appl));
  endtask

  task automatic stray_ack();
    iLOAD_ACK = 1'b1;
    tick(1);
    iLOAD_ACK = 1'b0;
    check_val("stray_gsel", int'(oGAMMA_SEL), code_of(m_appl));
    check_val("stray_req", int'(oLOAD_REQ), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_dig"}, int'(oDIG), 1);
    check_val({tag, "_gsel"}, int'(oGAMMA_SEL), 0);
    check_val({tag, "_lsel"}, int'(oLOAD_SEL), 0);
    check_val({tag, "_req"}, int'(oLOAD_REQ), 0);
    check_val({tag, "_busy"}, int'(oBUSY), 0);
  endtask

  initial begin
    tick(3);
    iRST_N = 1'b1;
    tick(2);
    check_reset_vals("rst");

    glitch();
    press(1, 0);
    check_val("up_dig", int'(oDIG), 10'h020);
    frame();
    ack(3, 0);

    press(0, 1);
    frame();
    ack(0, 0);
    for (int i = 0; i < 5; i++) press(0, 1);
    check_val("sat_lo", int'(oDIG), 10'h002);
    frame();
    ack(1, 0);
    for (int i = 0; i < 14; i++) press(1, 0);
    check_val("sat_hi", int'(oDIG), 10'h200);
    frame();
    ack(0, 0);

    for (int i = 0; i < 4; i++) press(0, 1);
    frame();
    check_val("req5_sel", int'(oLOAD_SEL), 5);
    ack(2, 2);
    check_val("req5_gsel", int'(oGAMMA_SEL), 5);
    frame();
    check_val("next_sel", int'(oLOAD_SEL), 0);
    ack(1, 0);

    press(1, 1);
    press(1, 0);
    press(0, 1);
    frame();

    press(1, 0);
    frame();
    tick(1);
    #2 iRST_N = 1'b0;
    #1 check_reset_vals("rst_req");
    m_pend = 4; m_appl = 4; m_latch = 4; in_req = 0;
    tick(2);
    iRST_N = 1'b1;
    tick(2);
    check_reset_vals("rst_rel");

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: press(1, 0);
        1: press(0, 1);
        2: glitch();
        3: begin
          frame();
          if (in_req) ack($urandom_range(0, 3), $urandom_range(0, 2));
        end
        4: stray_ack();
        default: press(1, 1);
      endcase
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
